uart_boot_io: RTL and testbench

// - UART boot/IO front-end of the pipelined core (no-DDR build); one 8N1 receiver and one 8N1 transmitter.
// - Loads PROG_WORDS program words into instruction memory, then handshakes with 0xAA.
// - Then loads DATA_WORDS data words into data memory, then releases the core (rstn_start).
// - In RUN it passes received bytes to the core and transmits bytes from the core.

---
 rtl/uart_boot_io_if.sv | 25 ++
 rtl/uart_boot_io.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_boot_io.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_io_if.sv
// Memory-write and core-side byte I/O bundle of the UART boot front-end.
// The master side is the boot front-end; the slave side is the pipelined core and its memories.
interface uart_boot_io_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        rstn_start;
  logic        input_sig;
  logic [7:0]  in_byte;
  logic        output_sig;
  logic [7:0]  out_byte;
  logic        output_busy;

  modport master (
    output memwrite, dataadr, writedata, rstn_start,
    output input_sig, in_byte, output_busy,
    input  output_sig, out_byte
  );

  modport slave (
    input  memwrite, dataadr, writedata, rstn_start,
    input  input_sig, in_byte, output_busy,
    output output_sig, out_byte
  );
endinterface

// File: rtl/uart_boot_io.sv
// UART boot loader and run-time byte I/O for the pipelined core (8N1 RX and TX).
// Define LOAD_CHECKSUM_EN to send an 8-bit sum of all loaded bytes before entering RUN.
module uart_boot_io #(
  parameter int          CLK_PER_HALF_BIT = 30,
  parameter int          PROG_WORDS       = 3,
  parameter int          DATA_WORDS       = 325,
  parameter logic [31:0] PROG_BASE        = 32'h0000_0000,
  parameter logic [31:0] DATA_BASE        = 32'h0001_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rxd,
  output logic          txd,
  output logic          rts,
  output logic [1:0]    stat1,
  output logic [31:0]   data_count,
  uart_boot_io_if.master bus
);

  localparam int          BIT_CYC   = 2 * CLK_PER_HALF_BIT;
  localparam logic [15:0] HALF_LAST = 16'(CLK_PER_HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
  localparam logic [31:0] PROG_LAST = 32'(PROG_WORDS - 1);
  localparam logic [31:0] DATA_LAST = 32'(DATA_WORDS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {
    S_LOAD_PROG,
    S_ACK_SEND,
    S_ACK_WAIT,
    S_LOAD_DATA,
`ifdef LOAD_CHECKSUM_EN
    S_CSUM_SEND,
    S_CSUM_WAIT,
`endif
    S_RUN
  } main_state_t;

`ifdef LOAD_CHECKSUM_EN
  localparam main_state_t END_OF_LOAD = S_CSUM_SEND;
`else
  localparam main_state_t END_OF_LOAD = S_RUN;
`endif

  // ---------------- receiver ----------------
  rx_state_t   rx_state, rx_next;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic        rx_stop_ok, rx_drop, rx_done1, rx_valid;
  logic        start_det, rx_half, rx_tick;
  logic        rts_busy;

  assign start_det = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
  assign rx_half   = (rx_cnt == HALF_LAST);
  assign rx_tick   = (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next    = rx_state;
    rx_stop_ok = 1'b0;
    rx_drop    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (start_det) rx_next = RX_START;
      RX_START: if (rx_half) begin
                  if (!rx_sync) rx_next = RX_DATA;
                  else begin
                    rx_next = RX_IDLE;
                    rx_drop = 1'b1;
                  end
                end
      RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) begin
                  rx_next    = RX_IDLE;
                  rx_stop_ok = rx_sync;
                  rx_drop    = !rx_sync;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Sampling counter restarts at mid-start-bit so every later sample lands mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_done1 <= 1'b0;
      rx_valid <= 1'b0;
      rts_busy <= 1'b0;
    end else begin
      rx_done1 <= rx_stop_ok;
      rx_valid <= rx_done1;
      if (rx_state == RX_IDLE || (rx_state == RX_START && rx_half) ||
          ((rx_state == RX_DATA || rx_state == RX_STOP) && rx_tick))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == RX_START)
        rx_bits <= '0;
      else if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bits  <= rx_bits + 3'd1;
      end
      if (start_det)
        rts_busy <= 1'b1;
      else if (rx_valid || rx_drop)
        rts_busy <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bits;
  logic [7:0]  tx_shift;
  logic        tx_go, tx_busy, tx_tick;
  logic [7:0]  tx_data;

  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_go) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bits == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt  <= '0;
      tx_bits <= '0;
      if (tx_go) tx_shift <= tx_data;
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_state == TX_DATA) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bits  <= tx_bits + 3'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign txd = (tx_state == TX_START) ? 1'b0 :
               (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  // ---------------- boot sequencer ----------------
  main_state_t st, st_next;
  logic [1:0]  pos;
  logic [23:0] partial;
  logic [31:0] idx;
  logic        word_done, loading;
  logic        memwrite_r, input_sig_r;
  logic [31:0] dataadr_r, writedata_r;
  logic [7:0]  in_byte_r;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign loading   = (st == S_LOAD_PROG) || (st == S_LOAD_DATA);
  assign word_done = rx_valid && (pos == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_LOAD_PROG;
    else       st <= st_next;
  end

  always_comb begin
    st_next = st;
    tx_go   = 1'b0;
    tx_data = 8'h00;
    case (st)
      S_LOAD_PROG: if (word_done && idx == PROG_LAST) st_next = S_ACK_SEND;
      S_ACK_SEND: begin
        tx_go   = 1'b1;
        tx_data = 8'hAA;
        st_next = S_ACK_WAIT;
      end
      S_ACK_WAIT:  if (!tx_busy) st_next = (DATA_WORDS == 0) ? END_OF_LOAD : S_LOAD_DATA;
      S_LOAD_DATA: if (word_done && idx == DATA_LAST) st_next = END_OF_LOAD;
`ifdef LOAD_CHECKSUM_EN
      S_CSUM_SEND: begin
        tx_go   = 1'b1;
        tx_data = csum;
        st_next = S_CSUM_WAIT;
      end
      S_CSUM_WAIT: if (!tx_busy) st_next = S_RUN;
`endif
      S_RUN: if (bus.output_sig && !tx_busy) begin
        tx_go   = 1'b1;
        tx_data = bus.out_byte;
      end
      default: st_next = S_LOAD_PROG;
    endcase
  end

  // Big-endian word assembly; the index restarts for the data region during ACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos         <= '0;
      partial     <= '0;
      idx         <= '0;
      data_count  <= '0;
      memwrite_r  <= 1'b0;
      dataadr_r   <= '0;
      writedata_r <= '0;
      input_sig_r <= 1'b0;
      in_byte_r   <= '0;
`ifdef LOAD_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      memwrite_r  <= 1'b0;
      input_sig_r <= 1'b0;
      if (st == S_ACK_SEND || st == S_ACK_WAIT) begin
        pos <= '0;
        idx <= '0;
      end else if (loading && rx_valid) begin
        partial <= {partial[15:0], rx_shift};
        pos     <= pos + 2'd1;
`ifdef LOAD_CHECKSUM_EN
        csum    <= csum + rx_shift;
`endif
        if (pos == 2'd3) begin
          memwrite_r  <= 1'b1;
          writedata_r <= {partial, rx_shift};
          dataadr_r   <= ((st == S_LOAD_PROG) ? PROG_BASE : DATA_BASE) + {idx[29:0], 2'b00};
          idx         <= idx + 32'd1;
          if (data_count != 32'hFFFF_FFFF) data_count <= data_count + 32'd1;
        end
      end
      if (st == S_RUN && rx_valid) begin
        in_byte_r   <= rx_shift;
        input_sig_r <= 1'b1;
      end
    end
  end

  always_comb begin
    stat1 = 2'b00;
    case (st)
      S_LOAD_PROG:             stat1 = 2'b00;
      S_ACK_SEND, S_ACK_WAIT:  stat1 = 2'b01;
      S_RUN:                   stat1 = 2'b11;
      default:                 stat1 = 2'b10;
    endcase
  end

  assign rts             = !(st == S_ACK_SEND || st == S_ACK_WAIT) && !rts_busy;
  assign bus.memwrite    = memwrite_r;
  assign bus.dataadr     = dataadr_r;
  assign bus.writedata   = writedata_r;
  assign bus.rstn_start  = (st == S_RUN);
  assign bus.input_sig   = input_sig_r;
  assign bus.in_byte     = in_byte_r;
  assign bus.output_busy = tx_busy;

endmodule

// File: tb/tb_uart_boot_io.sv
// Directed bench for uart_boot_io: program/data load, ACK, RUN byte I/O, framing error and reset.
// DATA_WORDS is reduced to 3 to keep the run short; everything else uses the default timing.
module tb_uart_boot_io;
  localparam int HALF = 30;
  localparam int BIT  = 60;
  localparam int DW   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic        txd;
  logic        rts;
  logic [1:0]  stat1;
  logic [31:0] data_count;

  uart_boot_io_if bus();

  uart_boot_io #(
    .CLK_PER_HALF_BIT(HALF),
    .PROG_WORDS(3),
    .DATA_WORDS(DW),
    .PROG_BASE(32'h0000_0000),
    .DATA_BASE(32'h0001_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .txd(txd),
    .rts(rts),
    .stat1(stat1),
    .data_count(data_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Passive monitors only ever append or count; the stimulus reads them by index.
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  logic [9:0]  tx_q[$];
  logic [9:0]  frame;
  int          ack_cycles = 0;
  int          ack_rts_high = 0;
  int          busy_cycles = 0;
  int          in_pulses = 0;
  logic [7:0]  last_in = 8'h00;

  always @(negedge clk) begin
    if (bus.memwrite === 1'b1) begin
      wr_adr_q.push_back(bus.dataadr);
      wr_dat_q.push_back(bus.writedata);
    end
    if (stat1 === 2'b01) begin
      ack_cycles++;
      if (rts !== 1'b0) ack_rts_high++;
    end
    if (bus.output_busy === 1'b1) busy_cycles++;
    if (bus.input_sig === 1'b1) begin
      in_pulses++;
      last_in = bus.in_byte;
    end
  end

  // Independent 8N1 decoder of txd sampling at mid-bit: frame[0]=start ... frame[9]=stop.
  always begin
    @(negedge txd);
    repeat (HALF) @(negedge clk);
    frame[0] = txd;
    for (int i = 1; i < 10; i++) begin
      repeat (BIT) @(negedge clk);
      frame[i] = txd;
    end
    tx_q.push_back(frame);
  end

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic waitStat(input logic [1:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (stat1 !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {30'b0, stat1}, {30'b0, target});
  endtask

  task automatic waitTx(input int count, input int budget);
    int n;
    n = 0;
    while (tx_q.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx frame arrived", tx_q.size(), count);
  endtask

  logic [7:0] prog_bytes [12];
  int         wr0;
  int         nframes;
  int         busy0;
  int         pulses0;

  initial begin
    prog_bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                   8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    rxd = 1'b1;
    bus.output_sig = 1'b0;
    bus.out_byte = 8'h00;
    reset = 1'b1;
    repeat (5) @(negedge clk);

    checkOutput("reset txd", txd, 1);
    checkOutput("reset rts", rts, 1);
    checkOutput("reset stat1", stat1, 0);
    checkOutput("reset data_count", data_count, 0);
    checkOutput("reset memwrite", bus.memwrite, 0);
    checkOutput("reset dataadr", bus.dataadr, 0);
    checkOutput("reset writedata", bus.writedata, 0);
    checkOutput("reset rstn_start", bus.rstn_start, 0);
    checkOutput("reset input_sig", bus.input_sig, 0);
    checkOutput("reset in_byte", bus.in_byte, 0);
    checkOutput("reset output_busy", bus.output_busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Program load: three big-endian words.
    for (int i = 0; i < 12; i++) applyStimulus(prog_bytes[i], 1'b1);
    checkOutput("prog write count", wr_adr_q.size(), 3);
    if (wr_adr_q.size() >= 3) begin
      checkOutput("prog adr0", wr_adr_q[0], 32'h0000_0000);
      checkOutput("prog dat0", wr_dat_q[0], 32'h0011_2233);
      checkOutput("prog adr1", wr_adr_q[1], 32'h0000_0004);
      checkOutput("prog dat1", wr_dat_q[1], 32'h4455_6677);
      checkOutput("prog adr2", wr_adr_q[2], 32'h0000_0008);
      checkOutput("prog dat2", wr_dat_q[2], 32'h8899_AABB);
    end
    checkOutput("prog data_count", data_count, 3);
    checkOutput("ack stat1", stat1, 2'b01);

    waitStat(2'b10, 1000, "stat1 to LOAD_DATA");
    checkOutput("ack frame count", tx_q.size(), 1);
    if (tx_q.size() >= 1) checkOutput("ack frame", tx_q[0], {1'b1, 8'hAA, 1'b0});
    checkOutput("rts high in ack", ack_rts_high, 0);
    checkOutput("ack duration", (ack_cycles >= 600 && ack_cycles <= 610), 1);

    // Data load: word k = k.
    for (int k = 0; k < DW; k++) begin
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'(k), 1'b1);
    end
    waitStat(2'b11, 200, "stat1 to RUN");
    checkOutput("data write count", wr_adr_q.size(), 3 + DW);
    for (int k = 0; k < DW; k++) begin
      if (wr_adr_q.size() > 3 + k) begin
        checkOutput("data adr", wr_adr_q[3 + k], 32'h0001_0000 + 32'(4 * k));
        checkOutput("data dat", wr_dat_q[3 + k], 32'(k));
      end
    end
    checkOutput("run data_count", data_count, 3 + DW);
    checkOutput("run rstn_start", bus.rstn_start, 1);
    checkOutput("run rts", rts, 1);

    // RUN receive.
    pulses0 = in_pulses;
    applyStimulus(8'h5A, 1'b1);
    checkOutput("run input_sig pulses", in_pulses - pulses0, 1);
    checkOutput("run pulse byte", last_in, 8'h5A);
    checkOutput("run in_byte", bus.in_byte, 8'h5A);

    // RUN transmit; a second strobe while busy must be ignored.
    nframes = tx_q.size();
    busy0 = busy_cycles;
    @(negedge clk);
    bus.output_sig = 1'b1;
    bus.out_byte = 8'hC3;
    @(negedge clk);
    bus.output_sig = 1'b0;
    bus.out_byte = 8'h00;
    repeat (100) @(negedge clk);
    bus.output_sig = 1'b1;
    bus.out_byte = 8'h3C;
    @(negedge clk);
    bus.output_sig = 1'b0;
    waitTx(nframes + 1, 800);
    repeat (700) @(negedge clk);
    checkOutput("run frames total", tx_q.size(), nframes + 1);
    if (tx_q.size() > nframes) checkOutput("run tx frame", tx_q[nframes], {1'b1, 8'hC3, 1'b0});
    checkOutput("run busy cycles", busy_cycles - busy0, 600);

    // Reset in the middle of an incoming frame while in RUN.
    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        repeat (300) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrun reset stat1", stat1, 0);
        checkOutput("midrun reset data_count", data_count, 0);
        checkOutput("midrun reset rts", rts, 1);
        checkOutput("midrun reset rstn_start", bus.rstn_start, 0);
        reset = 1'b0;
      end
    join

    // Partial word then reset mid-load: assembly must restart at byte 0, address 0.
    applyStimulus(8'hAB, 1'b1);
    applyStimulus(8'hCD, 1'b1);
    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        repeat (300) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    checkOutput("midload reset stat1", stat1, 0);

    // Framing error inside a word: that byte is dropped.
    wr0 = wr_adr_q.size();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b1);
    checkOutput("framing no write", wr_adr_q.size(), wr0);
    checkOutput("framing rts", rts, 1);
    applyStimulus(8'h55, 1'b1);
    checkOutput("framing write count", wr_adr_q.size(), wr0 + 1);
    if (wr_adr_q.size() > wr0) begin
      checkOutput("framing adr", wr_adr_q[wr0], 32'h0000_0000);
      checkOutput("framing dat", wr_dat_q[wr0], 32'h1122_4455);
    end
    checkOutput("framing data_count", data_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
